nn_dense_layer: RTL and testbench

- Parametrised fully-connected neural-network layer engine.
- Successor to the fixed two-input XOR network core; sits in the same slot, between an input ROM/RAM and an output RAM.
- On `fill`, loads N_IN signed fixed-point inputs over a memory read port. On `req`, computes N_OUT neurons (dot product + bias, shift, saturate, selectable activation) with one MAC per cycle, then writes the results to an output memory.
- Uses the same req/fill/ack_fill/ack_network handshake as the current network core.

---
 rtl/nn_pkg.sv | 49 ++++
 rtl/nn_mac_unit.sv | 44 ++++
 rtl/nn_dense_layer.sv | 138 +++++++++++++
 tb/tb_nn_dense_layer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense-layer engine and later layers.
// sat_shift is the common output transform: floor shift, clamp, activation.
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_ID   = 2'd0,
    ACT_RELU = 2'd1,
    ACT_STEP = 2'd2
  } act_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FILL_ACK,
    ST_CALC,
    ST_WRITE,
    ST_NET_ACK
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Accumulator arrives sign-extended to 64 bits so one function serves any layer width.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int width, input int frac,
                                                   input act_t act);
    logic signed [63:0] s, hi, lo;
    s  = acc >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    case (act)
      ACT_RELU: if (s < 0) s = 64'sd0;
      ACT_STEP: s = (s > 0) ? (64'sd1 <<< frac) : 64'sd0;
      default:  ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Multiply-accumulate datapath: one product or aligned bias per cycle into acc_q.
// Result is a pure function of acc_q, valid the cycle after the bias term lands.
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4,
  parameter int ACCW  = 19,
  parameter int ACT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    mul_en,
  input  logic                    bias_en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] w,
  output logic signed [WIDTH-1:0] y
);

  logic signed [ACCW-1:0]    acc_q, acc_d;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [63:0]        y_wide;

  always_comb begin
    prod  = (2*WIDTH)'(a) * (2*WIDTH)'(w);
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (mul_en)
      acc_d = acc_q + ACCW'(prod);
    else if (bias_en)
      acc_d = acc_q + (ACCW'(w) <<< FRAC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign y_wide = sat_shift(64'(acc_q), WIDTH, FRAC, act_t'(ACT));
  assign y      = y_wide[WIDTH-1:0];

endmodule

// File: rtl/nn_dense_layer.sv
// Fully-connected layer: fill loads N_IN inputs, req computes N_OUT neurons at one MAC/cycle.
// fill->ack_fill in N_IN cycles; req->ack_network in N_OUT*(N_IN+2) cycles; four-phase handshakes.
module nn_dense_layer
  import nn_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1,
  parameter int WIDTH = 8,
  parameter int FRAC  = 4,
  parameter int ACT   = 2,
  parameter int IAW   = max2(1, clog2(N_IN)),
  parameter int OAW   = max2(1, clog2(N_OUT)),
  parameter int WAW   = max2(1, clog2(N_OUT * (N_IN + 1)))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fill,
  input  logic                    req,
  output logic                    ack_fill,
  output logic                    ack_network,
  output logic                    trig_r,
  output logic [IAW-1:0]          abus_r,
  input  logic signed [WIDTH-1:0] dbus_r,
  output logic                    w_trig_r,
  output logic [WAW-1:0]          w_abus_r,
  input  logic signed [WIDTH-1:0] w_dbus_r,
  output logic                    trig_w,
  output logic [OAW-1:0]          abus_w,
  output logic signed [WIDTH-1:0] dbus_w
);

  localparam int JW   = max2(1, clog2(N_IN + 1));
  localparam int ACCW = 2 * WIDTH + clog2(N_IN + 1) + 1;

  state_t                  state_q, state_d;
  logic [IAW-1:0]          i_q, i_d;
  logic [JW-1:0]           j_q, j_d;
  logic [OAW-1:0]          o_q, o_d;
  logic [WAW-1:0]          wa_q, wa_d;
  logic signed [WIDTH-1:0] inp_q [N_IN];
  logic signed [WIDTH-1:0] inp_d [N_IN];
  logic signed [WIDTH-1:0] mac_a, mac_y;
  logic                    is_bias;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    o_d     = o_q;
    wa_d    = wa_q;
    inp_d   = inp_q;
    case (state_q)
      ST_IDLE: begin
        if (fill) begin
          state_d = ST_FILL;
          i_d     = '0;
        end else if (req) begin
          state_d = ST_CALC;
          j_d     = '0;
          o_d     = '0;
          wa_d    = '0;
        end
      end
      ST_FILL: begin
        inp_d[i_q] = dbus_r;
        if (i_q == IAW'(N_IN - 1)) state_d = ST_FILL_ACK;
        else                       i_d     = i_q + 1'b1;
      end
      ST_FILL_ACK: if (!fill) state_d = ST_IDLE;
      ST_CALC: begin
        // Weight address runs linearly across neurons, so it never needs a multiply.
        wa_d = wa_q + 1'b1;
        if (j_q == JW'(N_IN)) state_d = ST_WRITE;
        else                  j_d     = j_q + 1'b1;
      end
      ST_WRITE: begin
        j_d = '0;
        if (o_q == OAW'(N_OUT - 1)) begin
          state_d = ST_NET_ACK;
        end else begin
          o_d     = o_q + 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_NET_ACK: if (!req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      o_q     <= '0;
      wa_q    <= '0;
      for (int k = 0; k < N_IN; k++) inp_q[k] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      o_q     <= o_d;
      wa_q    <= wa_d;
      inp_q   <= inp_d;
    end
  end

  assign is_bias = (j_q == JW'(N_IN));
  assign mac_a   = (j_q < JW'(N_IN)) ? inp_q[j_q[IAW-1:0]] : '0;

  nn_mac_unit #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACCW  (ACCW),
    .ACT   (ACT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == ST_WRITE),
    .mul_en  ((state_q == ST_CALC) && !is_bias),
    .bias_en ((state_q == ST_CALC) && is_bias),
    .a       (mac_a),
    .w       (w_dbus_r),
    .y       (mac_y)
  );

  // Buses are gated by their strobes so every output reads zero outside an access.
  assign trig_r      = (state_q == ST_FILL);
  assign abus_r      = trig_r ? i_q : '0;
  assign w_trig_r    = (state_q == ST_CALC);
  assign w_abus_r    = w_trig_r ? wa_q : '0;
  assign trig_w      = (state_q == ST_WRITE);
  assign abus_w      = trig_w ? o_q : '0;
  assign dbus_w      = trig_w ? mac_y : '0;
  assign ack_fill    = (state_q == ST_FILL_ACK);
  assign ack_network = (state_q == ST_NET_ACK);

endmodule

// File: tb/tb_nn_dense_layer.sv
// Bench for nn_dense_layer: three N_IN=2/N_OUT=3 instances (step, identity, ReLU) with
// falling-edge memory models; expected writes are queued at stimulus time and popped on trig_w.
module tb_nn_dense_layer;

  localparam int NDUT  = 3;
  localparam int N_IN  = 2;
  localparam int N_OUT = 3;
  localparam int CALC_CYC = N_OUT * (N_IN + 2);

  typedef struct {
    int              dut;
    logic [1:0]      addr;
    logic signed [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic fill [NDUT];
  logic req  [NDUT];
  wire  ack_fill [NDUT];
  wire  ack_net  [NDUT];
  wire  trig_r   [NDUT];
  wire  w_trig_r [NDUT];
  wire  trig_w   [NDUT];
  wire  [0:0] abus_r   [NDUT];
  wire  [3:0] w_abus_r [NDUT];
  wire  [1:0] abus_w   [NDUT];
  wire  signed [7:0] dbus_w [NDUT];
  logic signed [7:0] dbus_r   [NDUT];
  logic signed [7:0] w_dbus_r [NDUT];

  logic signed [7:0] imem [NDUT][N_IN];
  logic signed [7:0] wmem [NDUT][16];
  int  xin [NDUT][N_IN];
  wr_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int A = (g == 0) ? 2 : ((g == 1) ? 0 : 1);
    nn_dense_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(8), .FRAC(4), .ACT(A)) u_dut (
      .clk(clk), .rst(rst), .fill(fill[g]), .req(req[g]),
      .ack_fill(ack_fill[g]), .ack_network(ack_net[g]),
      .trig_r(trig_r[g]), .abus_r(abus_r[g]), .dbus_r(dbus_r[g]),
      .w_trig_r(w_trig_r[g]), .w_abus_r(w_abus_r[g]), .w_dbus_r(w_dbus_r[g]),
      .trig_w(trig_w[g]), .abus_w(abus_w[g]), .dbus_w(dbus_w[g])
    );
  end

  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      dbus_r[g]   <= imem[g][abus_r[g]];
      w_dbus_r[g] <= wmem[g][w_abus_r[g]];
    end
  end

  function automatic int act_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 0 : 1);
  endfunction

  // Reference neuron: Q.FRAC dot product, floor shift, clamp, then activation.
  function automatic logic signed [7:0] model(input int act, input int x0, input int x1,
                                              input int w0, input int w1, input int b);
    int a, s;
    logic [31:0] r;
    a = x0 * w0 + x1 * w1 + b * 16;
    s = a >>> 4;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (act == 1 && s < 0) s = 0;
    if (act == 2) s = (s > 0) ? 16 : 0;
    r = s;
    return r[7:0];
  endfunction

  task automatic load_weights(input int g, input int w[9]);
    for (int k = 0; k < 16; k++) wmem[g][k] = (k < 9) ? 8'(w[k]) : 8'sd0;
    for (int o = 0; o < N_OUT; o++)
      exp_q.push_back('{dut: g, addr: 2'(o),
                        data: model(act_of(g), xin[g][0], xin[g][1], w[o*3], w[o*3+1], w[o*3+2])});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      fill[g] = 1'b0;
      req[g]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      logic [23:0] v;
      v = {ack_fill[g], ack_net[g], trig_r[g], w_trig_r[g], trig_w[g], abus_r[g], w_abus_r[g], abus_w[g], dbus_w[g]};
      n_assert++;
      if (v !== 24'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got %h, want 0", g, v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fill(input int g, input int x0, input int x1);
    int  c;
    bit  seen;
    imem[g][0] = 8'(x0);
    imem[g][1] = 8'(x1);
    xin[g][0]  = x0;
    xin[g][1]  = x1;
    @(posedge clk); #1 fill[g] = 1'b1;
    @(posedge clk);
    c = 0;
    seen = 0;
    while (!seen && c < 20) begin
      c++;
      @(negedge clk);
      if (c <= N_IN) begin
        n_assert++;
        if (trig_r[g] !== 1'b1 || abus_r[g] !== 1'(c - 1)) begin
          n_fail++;
          $display("FAIL fill_read dut%0d cyc%0d: trig_r=%b abus_r=%0d, want 1/%0d", g, c, trig_r[g], abus_r[g], c - 1);
        end
      end
      if (ack_fill[g] === 1'b1) begin
        seen = 1;
        n_assert++;
        if (c != N_IN + 1) begin
          n_fail++;
          $display("FAIL ack_fill_latency dut%0d: first seen cycle %0d, want %0d", g, c, N_IN + 1);
        end
      end
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $display("FAIL ack_fill_timeout dut%0d: got none in 20 cycles, want ack_fill", g);
    end
    @(posedge clk); #1 fill[g] = 1'b0;
    @(negedge clk);
    n_assert++;
    if (ack_fill[g] !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_fill_hold dut%0d: got %b, want 1", g, ack_fill[g]);
    end
    @(negedge clk);
    n_assert++;
    if (ack_fill[g] !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_fill_drop dut%0d: got %b, want 0", g, ack_fill[g]);
    end
  endtask

  task automatic test_calc(input int g, input int w[9]);
    int  c, nw;
    bit  done;
    wr_t e;
    load_weights(g, w);
    @(posedge clk); #1 req[g] = 1'b1;
    @(posedge clk);
    c = 0;
    nw = 0;
    done = 0;
    while (!done && c < 100) begin
      c++;
      @(negedge clk);
      if (c <= CALC_CYC) begin
        int p, o;
        logic [4:0] want;
        p = (c - 1) % (N_IN + 2);
        o = (c - 1) / (N_IN + 2);
        want = (p <= N_IN) ? {1'b1, 4'(o * (N_IN + 1) + p)} : 5'h0;
        n_assert++;
        if ({w_trig_r[g], w_abus_r[g]} !== want) begin
          n_fail++;
          $display("FAIL weight_read dut%0d cyc%0d: got %h, want %h", g, c, {w_trig_r[g], w_abus_r[g]}, want);
        end
      end
      if (trig_w[g] === 1'b1) begin
        nw++;
        n_assert++;
        if (c != nw * (N_IN + 2)) begin
          n_fail++;
          $display("FAIL write_cycle dut%0d: write %0d at cycle %0d, want %0d", g, nw, c, nw * (N_IN + 2));
        end
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected dut%0d: got addr %0d data %0d, want no write", g, abus_w[g], dbus_w[g]);
        end else begin
          e = exp_q.pop_front();
          if (e.dut != g || abus_w[g] !== e.addr || dbus_w[g] !== e.data) begin
            n_fail++;
            $display("FAIL write_data dut%0d: got addr %0d data %0d, want dut%0d addr %0d data %0d", g, abus_w[g], dbus_w[g], e.dut, e.addr, e.data);
          end
        end
      end
      if (ack_net[g] === 1'b1) begin
        done = 1;
        n_assert++;
        if (c != CALC_CYC + 1 || nw != N_OUT) begin
          n_fail++;
          $display("FAIL ack_network dut%0d: seen cycle %0d after %0d writes, want cycle %0d after %0d", g, c, nw, CALC_CYC + 1, N_OUT);
        end
      end
    end
    if (!done) begin
      n_assert++;
      n_fail++;
      $display("FAIL ack_network_timeout dut%0d: got none in 100 cycles, want ack_network", g);
    end
    @(posedge clk); #1 req[g] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (ack_net[g] !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_network_drop dut%0d: got %b, want 0", g, ack_net[g]);
    end
  endtask

  task automatic test_fill_and_req(input int g, input int w[9]);
    int  c;
    bit  got_ack, early_calc, done;
    wr_t e;
    imem[g][0] = 8'sd16;
    imem[g][1] = 8'sd16;
    xin[g][0]  = 16;
    xin[g][1]  = 16;
    load_weights(g, w);
    @(posedge clk); #1;
    fill[g] = 1'b1;
    req[g]  = 1'b1;
    c = 0;
    got_ack = 0;
    early_calc = 0;
    while (!got_ack && c < 20) begin
      c++;
      @(negedge clk);
      if (w_trig_r[g] === 1'b1 || trig_w[g] === 1'b1) early_calc = 1;
      if (ack_fill[g] === 1'b1) got_ack = 1;
    end
    n_assert++;
    if (!got_ack || early_calc) begin
      n_fail++;
      $display("FAIL fill_priority dut%0d: ack_fill=%0d compute_before_ack=%0d, want 1/0", g, got_ack, early_calc);
    end
    @(posedge clk); #1 fill[g] = 1'b0;
    c = 0;
    done = 0;
    while (!done && c < 100) begin
      c++;
      @(negedge clk);
      if (trig_w[g] === 1'b1) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL both_unexpected dut%0d: got addr %0d data %0d, want no write", g, abus_w[g], dbus_w[g]);
        end else begin
          e = exp_q.pop_front();
          if (abus_w[g] !== e.addr || dbus_w[g] !== e.data) begin
            n_fail++;
            $display("FAIL both_write dut%0d: got addr %0d data %0d, want addr %0d data %0d", g, abus_w[g], dbus_w[g], e.addr, e.data);
          end
        end
      end
      if (ack_net[g] === 1'b1) done = 1;
    end
    n_assert++;
    if (!done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL both_complete dut%0d: ack_network=%0d pending=%0d, want 1/0", g, done, exp_q.size());
    end
    @(posedge clk); #1 req[g] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_calc(input int g, input int w[9]);
    int  c;
    wr_t e;
    load_weights(g, w);
    // Only neuron 0 is written before the abort; drop the other two expectations.
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    @(posedge clk); #1 req[g] = 1'b1;
    @(posedge clk);
    for (c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (trig_w[g] === 1'b1) begin
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL abort_unexpected dut%0d: got write at cycle %0d, want none", g, c);
        end else begin
          e = exp_q.pop_front();
          if (abus_w[g] !== e.addr || dbus_w[g] !== e.data) begin
            n_fail++;
            $display("FAIL abort_write0 dut%0d: got addr %0d data %0d, want addr %0d data %0d", g, abus_w[g], dbus_w[g], e.addr, e.data);
          end
        end
      end
    end
    rst = 1'b1;
    #1;
    n_assert++;
    if ({ack_fill[g], ack_net[g], trig_r[g], w_trig_r[g], trig_w[g], w_abus_r[g], abus_w[g], dbus_w[g]} !== 19'h0) begin
      n_fail++;
      $display("FAIL abort_outputs dut%0d: got w_trig_r=%b w_abus_r=%0d trig_w=%b, want all 0", g, w_trig_r[g], w_abus_r[g], trig_w[g]);
    end
    req[g] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_pending dut%0d: got %0d queued writes, want 0", g, exp_q.size());
    end
    xin[g][0] = 0;
    xin[g][1] = 0;
    test_calc(g, '{127, 127, 3, -128, -128, -2, 5, 9, 100});
  endtask

  initial begin
    test_reset();
    test_fill(0, 16, 16);
    test_calc(0, '{16, 16, -24, 16, 0, 0, -16, 16, -24});
    test_fill(0, 16, 0);
    test_calc(0, '{16, 16, -24, 16, 0, 0, -16, 16, -24});
    test_calc(0, '{16, 16, -24, 0, 16, 0, 16, 0, 8});
    test_fill(1, 127, 127);
    test_calc(1, '{127, 127, 0, -128, -128, 0, -1, 0, 0});
    test_fill(2, 16, 16);
    test_calc(2, '{-16, 0, 0, 16, 8, 0, 0, 0, 5});
    test_fill_and_req(0, '{16, 16, -24, 16, 0, 0, -16, 16, -24});
    test_reset_mid_calc(1, '{127, 127, 0, -128, -128, 0, -1, 0, 0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
